// File: rtl/axi_udp_cmd_bridge_if.sv
// UDP word stream + AXI4 master bundle for the UDP command bridge.
// The bridge uses the master modport; the UDP core / AXI slave side uses slave.
interface axi_udp_cmd_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 2
);
    // UDP receive / transmit word interface
    logic                  udp_rx_en;
    logic [31:0]           udp_rx_data;
    logic                  udp_rx_done;
    logic                  udp_tx_start;
    logic [15:0]           udp_tx_byte_num;
    logic                  udp_tx_req;
    logic [31:0]           udp_tx_data;
    logic                  udp_tx_done;
    // AXI write address
    logic [ID_WIDTH-1:0]   m_awid;
    logic [ADDR_WIDTH-1:0] m_awaddr;
    logic [7:0]            m_awlen;
    logic [1:0]            m_awburst;
    logic                  m_awvalid;
    logic                  m_awready;
    // AXI write data
    logic [31:0]           m_wdata;
    logic [3:0]            m_wstrb;
    logic                  m_wlast;
    logic                  m_wvalid;
    logic                  m_wready;
    // AXI write response
    logic [ID_WIDTH-1:0]   m_bid;
    logic [1:0]            m_bresp;
    logic                  m_bvalid;
    logic                  m_bready;
    // AXI read address
    logic [ID_WIDTH-1:0]   m_arid;
    logic [ADDR_WIDTH-1:0] m_araddr;
    logic [7:0]            m_arlen;
    logic [1:0]            m_arburst;
    logic                  m_arvalid;
    logic                  m_arready;
    // AXI read data
    logic [ID_WIDTH-1:0]   m_rid;
    logic [31:0]           m_rdata;
    logic [1:0]            m_rresp;
    logic                  m_rlast;
    logic                  m_rvalid;
    logic                  m_rready;
    // status
    logic                  busy;
    logic [7:0]            drop_cnt;

    modport master (
        input  udp_rx_en, udp_rx_data, udp_rx_done, udp_tx_req, udp_tx_done,
        output udp_tx_start, udp_tx_byte_num, udp_tx_data,
        output m_awid, m_awaddr, m_awlen, m_awburst, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bid, m_bresp, m_bvalid,
        output m_bready,
        output m_arid, m_araddr, m_arlen, m_arburst, m_arvalid,
        input  m_arready,
        input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready,
        output busy, drop_cnt
    );

    modport slave (
        output udp_rx_en, udp_rx_data, udp_rx_done, udp_tx_req, udp_tx_done,
        input  udp_tx_start, udp_tx_byte_num, udp_tx_data,
        input  m_awid, m_awaddr, m_awlen, m_awburst, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready,
        output m_bid, m_bresp, m_bvalid,
        input  m_bready,
        input  m_arid, m_araddr, m_arlen, m_arburst, m_arvalid,
        output m_arready,
        output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready,
        input  busy, drop_cnt
    );
endinterface

// File: rtl/axi_udp_cmd_bridge.sv
// UDP command packet -> AXI4 burst master. Every accepted packet gets a reply
// carrying a status code; every AXI wait is bounded by TIMEOUT_CYC.
module axi_udp_cmd_bridge #(
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 2,
    parameter int BUF_DEPTH   = 256,
    parameter int TIMEOUT_CYC = 65535
) (
    input logic                    clk,
    input logic                    rst,
    axi_udp_cmd_bridge_if.master   bus
);
    localparam int IW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RX, S_AW, S_W, S_B, S_AR, S_R, S_REPLY_START, S_REPLY
    } state_t;

    state_t        r_state;
    logic [31:0]   r_hdr;
    logic [31:0]   r_addr;
    logic [9:0]    r_wcnt;
    logic          r_ovf;
    logic [3:0]    r_status;
    logic [8:0]    r_beat;
    logic [TW-1:0] r_tcnt;
    logic          r_awvalid, r_wvalid, r_wlast, r_bready, r_arvalid, r_rready;
    logic [31:0]   r_wdata;
    logic          r_tx_start;
    logic [15:0]   r_tx_byte_num;
    logic [31:0]   r_tx_data;
    logic [7:0]    r_drop_cnt;
    logic [31:0]   r_buf [BUF_DEPTH];

    // header fields of the command being processed
    logic [3:0]  w_op;
    logic [1:0]  w_burst;
    logic [7:0]  w_len;
    logic        w_is_wr, w_is_rd;
    assign w_op    = r_hdr[31:28];
    assign w_burst = r_hdr[27:26];
    assign w_len   = r_hdr[23:16];
    assign w_is_wr = (w_op == 4'd1);
    assign w_is_rd = (w_op == 4'd2);

    // write-data placement during RX: word index 2.. maps to buffer 0..
    logic [9:0] w_widx;
    logic       w_rx_word, w_rx_store, w_ovf_now;
    assign w_widx     = r_wcnt - 10'd2;
    assign w_rx_word  = (r_state == S_RX) && bus.udp_rx_en && (r_wcnt >= 10'd2);
    assign w_rx_store = w_rx_word && (w_widx < 10'(BUF_DEPTH));
    assign w_ovf_now  = w_rx_word && !(w_widx < 10'(BUF_DEPTH));

    // validation sees the word arriving with rx_done already counted
    logic [9:0] w_cnt_fin, w_cnt_exp;
    logic       w_bad;
    assign w_cnt_fin = r_wcnt + {9'd0, bus.udp_rx_en};
    assign w_cnt_exp = w_is_wr ? ({2'b00, w_len} + 10'd3) : 10'd2;
    assign w_bad     = !(w_is_wr || w_is_rd) || (w_burst == 2'd3) ||
                       (({1'b0, w_len} + 9'd1) > 9'(BUF_DEPTH)) ||
                       (w_cnt_fin != w_cnt_exp) || r_ovf || w_ovf_now;

    // read beats past len+1 are dropped on the floor
    logic w_r_store;
    assign w_r_store = (r_state == S_R) && bus.m_rvalid && r_rready &&
                       (r_beat <= {1'b0, w_len});

    // handshake / timeout bookkeeping for the AXI wait states
    logic w_axi_wait, w_acc, w_tmo;
    assign w_axi_wait = (r_state == S_AW) || (r_state == S_W) || (r_state == S_B) ||
                        (r_state == S_AR) || (r_state == S_R);
    assign w_tmo      = (r_tcnt == TW'(TIMEOUT_CYC - 1));

    // accepted-beat indication for whichever channel the FSM is waiting on
    always_comb begin
        w_acc = 1'b0;
        case (r_state)
            S_AW:    w_acc = bus.m_awready;
            S_W:     w_acc = bus.m_wready;
            S_B:     w_acc = bus.m_bvalid;
            S_AR:    w_acc = bus.m_arready;
            S_R:     w_acc = bus.m_rvalid;
            default: w_acc = 1'b0;
        endcase
    end

    logic [8:0] w_nbeat, w_pbeat;
    assign w_nbeat = r_beat + 9'd1;
    assign w_pbeat = r_beat - 9'd1;

    // single write port into the data buffer (RX write data or R read data)
    logic          w_buf_we;
    logic [IW-1:0] w_buf_waddr;
    logic [31:0]   w_buf_wdata;
    always_comb begin
        w_buf_we    = 1'b0;
        w_buf_waddr = '0;
        w_buf_wdata = '0;
        if (w_rx_store) begin
            w_buf_we    = 1'b1;
            w_buf_waddr = w_widx[IW-1:0];
            w_buf_wdata = bus.udp_rx_data;
        end else if (w_r_store) begin
            w_buf_we    = 1'b1;
            w_buf_waddr = r_beat[IW-1:0];
            w_buf_wdata = bus.m_rdata;
        end
    end

    // data buffer storage, no reset needed
    always_ff @(posedge clk) begin
        if (w_buf_we) r_buf[w_buf_waddr] <= w_buf_wdata;
    end

    // main control FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_hdr         <= '0;
            r_addr        <= '0;
            r_wcnt        <= '0;
            r_ovf         <= 1'b0;
            r_status      <= '0;
            r_beat        <= '0;
            r_tcnt        <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_wlast       <= 1'b0;
            r_bready      <= 1'b0;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_wdata       <= '0;
            r_tx_start    <= 1'b0;
            r_tx_byte_num <= '0;
            r_tx_data     <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_tx_start <= 1'b0;
            if (bus.udp_rx_done && (r_state != S_RX) && (r_drop_cnt != 8'hFF))
                r_drop_cnt <= r_drop_cnt + 8'd1;

            case (r_state)
                S_IDLE: if (bus.udp_rx_en) begin
                    r_hdr   <= bus.udp_rx_data;
                    r_wcnt  <= 10'd1;
                    r_ovf   <= 1'b0;
                    r_state <= S_RX;
                end
                S_RX: begin
                    if (bus.udp_rx_en) begin
                        if (r_wcnt == 10'd1) r_addr <= bus.udp_rx_data;
                        if (r_wcnt != 10'h3FF) r_wcnt <= r_wcnt + 10'd1;
                        if (w_ovf_now) r_ovf <= 1'b1;
                    end
                    if (bus.udp_rx_done) begin
                        r_tcnt   <= '0;
                        r_beat   <= '0;
                        r_status <= 4'd0;
                        if (w_bad) begin
                            r_status <= 4'd8;
                            r_state  <= S_REPLY_START;
                        end else if (w_is_wr) begin
                            r_awvalid <= 1'b1;
                            r_state   <= S_AW;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
                        end
                    end
                end
                S_AW: if (w_acc) begin
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b1;
                    r_wdata   <= r_buf[IW'(0)];
                    r_wlast   <= (w_len == 8'd0);
                    r_beat    <= '0;
                    r_state   <= S_W;
                end
                S_W: if (w_acc) begin
                    if (r_wlast) begin
                        r_wvalid <= 1'b0;
                        r_wlast  <= 1'b0;
                        r_bready <= 1'b1;
                        r_state  <= S_B;
                    end else begin
                        r_beat  <= w_nbeat;
                        r_wdata <= r_buf[w_nbeat[IW-1:0]];
                        r_wlast <= (w_nbeat == {1'b0, w_len});
                    end
                end
                S_B: if (w_acc) begin
                    r_bready <= 1'b0;
                    r_status <= {2'b00, bus.m_bresp};
                    r_state  <= S_REPLY_START;
                end
                S_AR: if (w_acc) begin
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b1;
                    r_beat    <= '0;
                    r_state   <= S_R;
                end
                S_R: if (w_acc) begin
                    if (r_beat <= {1'b0, w_len}) r_beat <= w_nbeat;
                    if ({2'b00, bus.m_rresp} > r_status) r_status <= {2'b00, bus.m_rresp};
                    if (bus.m_rlast) begin
                        r_rready <= 1'b0;
                        r_state  <= S_REPLY_START;
                    end
                end
                S_REPLY_START: begin
                    r_tx_start    <= 1'b1;
                    r_tx_byte_num <= (w_is_rd && (r_status < 4'd8)) ?
                                     {4'd0, ({2'b00, w_len} + 10'd2), 2'b00} : 16'd4;
                    r_beat        <= '0;
                    r_state       <= S_REPLY;
                end
                S_REPLY: begin
                    if (bus.udp_tx_req) begin
                        r_tx_data <= (r_beat == 9'd0) ? {w_op, r_status, w_len, r_hdr[15:0]}
                                                      : r_buf[w_pbeat[IW-1:0]];
                        if (r_beat != 9'h1FF) r_beat <= w_nbeat;
                    end
                    if (bus.udp_tx_done) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // watchdog: cleared by any accepted beat, fires a header-only status-9 reply
            if (w_axi_wait) begin
                if (w_acc) begin
                    r_tcnt <= '0;
                end else if (w_tmo) begin
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                    r_wlast   <= 1'b0;
                    r_bready  <= 1'b0;
                    r_arvalid <= 1'b0;
                    r_rready  <= 1'b0;
                    r_status  <= 4'd9;
                    r_state   <= S_REPLY_START;
                end else begin
                    r_tcnt <= r_tcnt + TW'(1);
                end
            end
        end
    end

    // output mapping; all derive from reset registers so they read 0 in reset
    assign bus.m_awid          = ID_WIDTH'(r_hdr[25:24]);
    assign bus.m_awaddr        = r_addr[ADDR_WIDTH-1:0];
    assign bus.m_awlen         = w_len;
    assign bus.m_awburst       = w_burst;
    assign bus.m_awvalid       = r_awvalid;
    assign bus.m_wdata         = r_wdata;
    assign bus.m_wstrb         = {4{r_wvalid}};
    assign bus.m_wlast         = r_wlast;
    assign bus.m_wvalid        = r_wvalid;
    assign bus.m_bready        = r_bready;
    assign bus.m_arid          = ID_WIDTH'(r_hdr[25:24]);
    assign bus.m_araddr        = r_addr[ADDR_WIDTH-1:0];
    assign bus.m_arlen         = w_len;
    assign bus.m_arburst       = w_burst;
    assign bus.m_arvalid       = r_arvalid;
    assign bus.m_rready        = r_rready;
    assign bus.udp_tx_start    = r_tx_start;
    assign bus.udp_tx_byte_num = r_tx_byte_num;
    assign bus.udp_tx_data     = r_tx_data;
    assign bus.busy            = !((r_state == S_IDLE) || (r_state == S_RX));
    assign bus.drop_cnt        = r_drop_cnt;

    // response IDs are not checked; single outstanding transaction
    logic w_unused;
    assign w_unused = ^{bus.m_bid, bus.m_rid, r_addr};
endmodule

// File: tb/tb_axi_udp_cmd_bridge.sv
// Directed bench for axi_udp_cmd_bridge with a hand-driven AXI slave.
module tb_axi_udp_cmd_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [31:0] pkt[$];
    logic [31:0] wd[8];
    logic        wl[8];
    int          nb;
    int          cnt;
    logic        saw_axi;

    axi_udp_cmd_bridge_if #(.ADDR_WIDTH(32), .ID_WIDTH(2)) bus();

    axi_udp_cmd_bridge #(.ADDR_WIDTH(32), .ID_WIDTH(2), .BUF_DEPTH(256), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return bus.m_awvalid;
            1: return bus.m_arvalid;
            2: return bus.m_bready;
            3: return bus.m_rready;
            4: return bus.udp_tx_start;
            default: return bus.m_wvalid;
        endcase
    endfunction

    // bounded wait; an expired bound shows up as a failed comparison
    task automatic wait_sig(input int sel, input string tag);
        for (int i = 0; i < 50 && !sig(sel); i++) begin
            saw_axi = saw_axi | bus.m_awvalid | bus.m_arvalid;
            tick();
        end
        chk(tag, {31'd0, sig(sel)}, 32'd1);
    endtask

    task automatic send_pkt();
        foreach (pkt[i]) begin
            bus.udp_rx_en = 1'b1; bus.udp_rx_data = pkt[i]; tick();
        end
        bus.udp_rx_en = 1'b0; bus.udp_rx_done = 1'b1; tick();
        bus.udp_rx_done = 1'b0;
    endtask

    task automatic req_chk(input string tag, input logic [31:0] exp);
        bus.udp_tx_req = 1'b1; tick(); bus.udp_tx_req = 1'b0;
        chk(tag, bus.udp_tx_data, exp);
    endtask

    task automatic tx_finish();
        bus.udp_tx_done = 1'b1; tick(); bus.udp_tx_done = 1'b0; tick();
        chk("idle_after_reply", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic aw_hs();
        wait_sig(0, "awvalid_seen");
        bus.m_awready = 1'b1; tick(); bus.m_awready = 1'b0;
    endtask

    // accept W beats until wlast, recording data/last per beat
    task automatic w_collect();
        nb = 0;
        bus.m_wready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.m_wvalid && nb < 8) begin
                wd[nb] = bus.m_wdata; wl[nb] = bus.m_wlast; nb++;
            end
            tick();
            if (nb > 0 && wl[nb-1]) break;
        end
        bus.m_wready = 1'b0;
    endtask

    task automatic b_resp(input logic [1:0] resp);
        wait_sig(2, "bready_seen");
        bus.m_bvalid = 1'b1; bus.m_bresp = resp; tick(); bus.m_bvalid = 1'b0;
    endtask

    initial begin
        bus.udp_rx_en = 0; bus.udp_rx_data = 0; bus.udp_rx_done = 0;
        bus.udp_tx_req = 0; bus.udp_tx_done = 0;
        bus.m_awready = 0; bus.m_wready = 0; bus.m_bid = 0; bus.m_bresp = 0; bus.m_bvalid = 0;
        bus.m_arready = 0; bus.m_rid = 0; bus.m_rdata = 0; bus.m_rresp = 0; bus.m_rlast = 0;
        bus.m_rvalid = 0;
        saw_axi = 0;

        // reset state
        #2;
        chk("rst_awvalid", {31'd0, bus.m_awvalid}, 32'd0);
        chk("rst_wvalid",  {31'd0, bus.m_wvalid}, 32'd0);
        chk("rst_txstart", {31'd0, bus.udp_tx_start}, 32'd0);
        chk("rst_busy",    {31'd0, bus.busy}, 32'd0);
        chk("rst_drop",    {24'd0, bus.drop_cnt}, 32'd0);
        chk("rst_txdata",  bus.udp_tx_data, 32'd0);
        tick(); rst = 1'b0; tick();

        // write burst: op1 burst1 id1 len3 seq 0x00A5 @0x1000
        pkt = '{32'h1503_00A5, 32'h0000_1000, 32'h11, 32'h22, 32'h33, 32'h44};
        send_pkt();
        wait_sig(0, "wr_awvalid");
        chk("wr_awaddr",  bus.m_awaddr, 32'h1000);
        chk("wr_awlen",   {24'd0, bus.m_awlen}, 32'd3);
        chk("wr_awid",    {30'd0, bus.m_awid}, 32'd1);
        chk("wr_awburst", {30'd0, bus.m_awburst}, 32'd1);
        chk("wr_busy",    {31'd0, bus.busy}, 32'd1);
        aw_hs();
        chk("wr_wstrb", {28'd0, bus.m_wstrb}, 32'hF);
        w_collect();
        chk("wr_beats", nb, 32'd4);
        chk("wr_d0", wd[0], 32'h11);
        chk("wr_d1", wd[1], 32'h22);
        chk("wr_d2", wd[2], 32'h33);
        chk("wr_d3", wd[3], 32'h44);
        chk("wr_last2", {31'd0, wl[2]}, 32'd0);
        chk("wr_last3", {31'd0, wl[3]}, 32'd1);
        b_resp(2'd0);
        wait_sig(4, "wr_txstart");
        chk("wr_bytes", {16'd0, bus.udp_tx_byte_num}, 32'd4);
        req_chk("wr_hdr", 32'h1003_00A5);
        tx_finish();

        // read burst len1 seq7 @0x2000, rresp 0 then 2
        pkt = '{32'h2401_0007, 32'h0000_2000};
        send_pkt();
        wait_sig(1, "rd_arvalid");
        chk("rd_araddr", bus.m_araddr, 32'h2000);
        chk("rd_arlen",  {24'd0, bus.m_arlen}, 32'd1);
        bus.m_arready = 1'b1; tick(); bus.m_arready = 1'b0;
        wait_sig(3, "rd_rready");
        bus.m_rvalid = 1; bus.m_rdata = 32'hDEAD; bus.m_rresp = 2'd0; bus.m_rlast = 0; tick();
        bus.m_rdata = 32'hBEEF; bus.m_rresp = 2'd2; bus.m_rlast = 1; tick();
        bus.m_rvalid = 0; bus.m_rlast = 0;
        wait_sig(4, "rd_txstart");
        chk("rd_bytes", {16'd0, bus.udp_tx_byte_num}, 32'd12);
        req_chk("rd_hdr", 32'h2201_0007);
        req_chk("rd_w0", 32'h0000_DEAD);
        req_chk("rd_w1", 32'h0000_BEEF);
        tx_finish();

        // bad op 5
        saw_axi = 0;
        pkt = '{32'h5000_0001, 32'h0000_8000};
        send_pkt();
        wait_sig(4, "op5_txstart");
        chk("op5_no_axi", {31'd0, saw_axi}, 32'd0);
        chk("op5_bytes", {16'd0, bus.udp_tx_byte_num}, 32'd4);
        req_chk("op5_hdr", 32'h5800_0001);
        tx_finish();

        // write len3 carrying only 2 data words
        saw_axi = 0;
        pkt = '{32'h1403_0002, 32'h0000_7000, 32'hA, 32'hB};
        send_pkt();
        wait_sig(4, "short_txstart");
        chk("short_no_axi", {31'd0, saw_axi}, 32'd0);
        chk("short_bytes", {16'd0, bus.udp_tx_byte_num}, 32'd4);
        req_chk("short_hdr", 32'h1803_0002);
        tx_finish();

        // awready never arrives: awvalid for exactly 16 cycles, status 9
        pkt = '{32'h1400_0003, 32'h0000_3000, 32'h55};
        send_pkt();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.m_awvalid) cnt++;
            else if (cnt > 0) break;
            tick();
        end
        chk("tmo_aw_cycles", cnt, 32'd16);
        wait_sig(4, "tmo_txstart");
        chk("tmo_bytes", {16'd0, bus.udp_tx_byte_num}, 32'd4);
        req_chk("tmo_hdr", 32'h1900_0003);
        tx_finish();

        // second packet ends while waiting on B: dropped, first reply intact
        pkt = '{32'h1400_0004, 32'h0000_4000, 32'h77};
        send_pkt();
        aw_hs();
        w_collect();
        chk("drop_wdata", wd[0], 32'h77);
        wait_sig(2, "drop_bready");
        pkt = '{32'h2400_0009, 32'h0000_0001};
        send_pkt();
        chk("drop_cnt", {24'd0, bus.drop_cnt}, 32'd1);
        b_resp(2'd0);
        wait_sig(4, "drop_txstart");
        chk("drop_bytes", {16'd0, bus.udp_tx_byte_num}, 32'd4);
        req_chk("drop_hdr", 32'h1000_0004);
        tx_finish();

        // reset mid-W burst
        pkt = '{32'h1403_0005, 32'h0000_5000, 32'h1, 32'h2, 32'h3, 32'h4};
        send_pkt();
        aw_hs();
        chk("mid_wvalid", {31'd0, bus.m_wvalid}, 32'd1);
        rst = 1'b1; #1;
        chk("mid_rst_wvalid", {31'd0, bus.m_wvalid}, 32'd0);
        chk("mid_rst_wdata",  bus.m_wdata, 32'd0);
        chk("mid_rst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_drop",   {24'd0, bus.drop_cnt}, 32'd0);
        chk("mid_rst_awaddr", bus.m_awaddr, 32'd0);
        tick(); rst = 1'b0; tick();
        chk("mid_no_start", {31'd0, bus.udp_tx_start}, 32'd0);

        // fresh single-beat read after reset, EXOKAY
        pkt = '{32'h2400_0008, 32'h0000_6000};
        send_pkt();
        wait_sig(1, "post_arvalid");
        chk("post_araddr", bus.m_araddr, 32'h6000);
        bus.m_arready = 1'b1; tick(); bus.m_arready = 1'b0;
        wait_sig(3, "post_rready");
        bus.m_rvalid = 1; bus.m_rdata = 32'hCAFE_F00D; bus.m_rresp = 2'd1; bus.m_rlast = 1; tick();
        bus.m_rvalid = 0; bus.m_rlast = 0;
        wait_sig(4, "post_txstart");
        chk("post_bytes", {16'd0, bus.udp_tx_byte_num}, 32'd8);
        req_chk("post_hdr", 32'h2100_0008);
        req_chk("post_w0", 32'hCAFE_F00D);
        tx_finish();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_udp_cmd_bridge.md
Name: axi_udp_cmd_bridge

Overview:
Parametrised successor of the UDP-command-to-AXI master path. It decodes UDP payload words into AXI4 write/read bursts with configurable address/ID width and buffer depth. Every command, good or bad, gets a UDP reply with a status code, and every AXI wait is guarded by a timeout. It sits between the udp core's rec/tx word interface and the AXI master port feeding the lab interconnect.

Parameters:
ADDR_WIDTH, 32, AXI address width (1..32); taken from the low bits of command word1.
ID_WIDTH, 2, AXI ID width; header bits [25:24] are zero-extended to this width.
BUF_DEPTH, 256, write/read data buffer depth in 32-bit words; must be a power of 2 and at most 256.
TIMEOUT_CYC, 65535, maximum cycles spent waiting on any single AXI handshake.

Ports:
clk  in  1  single clock for all logic, including the AXI side
rst  in  1  asynchronous, active-high reset
udp_rx_en  in  1  received payload word valid
udp_rx_data  in  32  received payload word
udp_rx_done  in  1  end-of-packet pulse
udp_tx_start  out  1  one-cycle reply start pulse
udp_tx_byte_num  out  16  reply length in bytes, valid with udp_tx_start
udp_tx_req  in  1  request for the next reply word
udp_tx_data  out  32  reply word, registered, valid the cycle after udp_tx_req
udp_tx_done  in  1  reply sent
m_awid/awaddr/awlen/awburst/awvalid, awready  out/in  ID_WIDTH/ADDR_WIDTH/8/2/1, 1  AXI AW channel
m_wdata/wstrb/wlast/wvalid, wready  out/in  32/4/1/1, 1  AXI W channel
m_bid/bresp/bvalid, bready  in/out  ID_WIDTH/2/1, 1  AXI B channel
m_arid/araddr/arlen/arburst/arvalid, arready  out/in  ID_WIDTH/ADDR_WIDTH/8/2/1, 1  AXI AR channel
m_rid/rdata/rresp/rlast/rvalid, rready  in/out  ID_WIDTH/32/2/1/1, 1  AXI R channel
busy  out  1  high in any state other than IDLE or RX
drop_cnt  out  8  saturating count of packets dropped while busy

Behaviour:
- Reset: all outputs 0, state IDLE, buffer pointers, counters and drop_cnt cleared. Assertion mid-transfer aborts immediately; no reply is sent.
- Command word0: [31:28] op (1 = write, 2 = read), [27:26] burst, [25:24] id, [23:16] len (beats-1), [15:0] seq. Word1 is the address. Write commands carry len+1 data words after word1.
- Reply header: {op, status[3:0], len, seq}. Status codes: 0-3 = AXI resp (OKAY, EXOKAY, SLVERR, DECERR), 8 = bad format, 9 = timeout.
- States and transitions:
  - IDLE -> RX on the first udp_rx_en.
  - RX: counts words. Write data goes to the buffer; data beyond BUF_DEPTH is discarded and the packet is flagged bad.
  - RX, on udp_rx_done: validate. Bad if op is not 1 or 2, burst==3, len+1 > BUF_DEPTH, or word count != (write ? len+3 : 2). Bad -> REPLY_START with status 8. Good write -> AW. Good read -> AR.
  - AW: awvalid held until awready -> W.
  - W: streams buffer words, wstrb=4'hF, wlast on beat len -> B.
  - B: bready=1; latch bresp -> REPLY_START.
  - AR: arvalid held until arready -> R.
  - R: rready=1 (space is guaranteed); store rdata; status = worst rresp seen. rlast -> REPLY_START. Beats after len+1 are discarded.
  - REPLY_START: pulse udp_tx_start. byte_num = 4 for write, bad or timeout replies; 4*(len+2) for a successful read -> REPLY.
  - REPLY: each udp_tx_req emits the header first, then buffer words. udp_tx_done -> IDLE.
- Timeout: a counter resets on entry to AW, W, B, AR or R and on every accepted beat. At TIMEOUT_CYC: drop all valid/ready signals, status 9, header-only reply. The downstream slave must then be reset by the system.
- udp_rx_done in any state other than RX: packet dropped, drop_cnt += 1 (saturating at 255). udp_rx_en outside IDLE/RX is ignored.
- udp_rx_en and udp_rx_done in the same cycle: the word is counted first, then validation runs.
- araddr/awaddr = word1[ADDR_WIDTH-1:0]; id zero-extended; awlen/arlen = len.

Test Plan:
- Write op=1, burst=1, id=1, len=3, seq=0x00A5, addr 0x1000, data 0x11..0x44 -> AW addr 0x1000 len 3; 4 W beats with wlast on beat 4; after bresp=0, reply 4 bytes, header 0x1003_00A5.
- Read len=1, seq=7, slave returns 0xDEAD, 0xBEEF with rresp 0 then 2 -> reply 12 bytes: 0x2201_0007, 0xDEAD, 0xBEEF.
- op=5, or write len=3 carrying only 2 data words -> no AXI activity; reply header with status 8.
- awready held low for TIMEOUT_CYC (shrunk to 16 in the bench) -> awvalid drops at cycle 16; reply status 9.
- Second packet's udp_rx_done arrives during B wait -> drop_cnt=1; first reply unaffected.
- rst asserted mid-W burst -> all outputs 0 next cycle; a new command afterwards completes normally.
